// File: rtl/ssd1306_init_sequencer_pkg.sv
// ssd1306_init_sequencer_pkg: opcodes, CTRL codes and FSM states shared by the init sequencer
package ssd1306_init_sequencer_pkg;
  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_CTRL  = 2'b11;
  localparam logic [7:0] CTRL_END    = 8'h00;
  localparam logic [7:0] CTRL_RES_LO = 8'h01;
  localparam logic [7:0] CTRL_RES_HI = 8'h02;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, SEND, DELAY, DONE, ERR} state_t;
  function automatic logic is_tx(input logic [1:0] op);
    return !op[1];
  endfunction
endpackage

// File: rtl/ssd1306_ms_timer.sv
// ssd1306_ms_timer: 1 ms prescaler plus ms down-counter; expired marks the final cycle of the wait
module ssd1306_ms_timer #(
  parameter int CYCLES_PER_MS = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] ms_count,
  output logic       expired
);
  localparam int PW = CYCLES_PER_MS > 1 ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRESET = PW'(CYCLES_PER_MS - 1);
  logic [PW-1:0] presc;
  logic [7:0] ms;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc <= '0;
      ms <= '0;
    end else if (load) begin
      presc <= PRESET;
      ms <= ms_count;
    end else if (ms != 8'd0) begin
      presc <= presc == '0 ? PRESET : presc - PW'(1);
      ms <= presc == '0 ? ms - 8'd1 : ms;
    end
  assign expired = ms == 8'd1 && presc == '0;
endmodule

// File: rtl/ssd1306_init_sequencer.sv
// ssd1306_init_sequencer: executes the SSD1306 init-script ROM (SPI bytes, ms delays, panel reset)
module ssd1306_init_sequencer
  import ssd1306_init_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 10,
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_dc,
  input  logic              tx_ready,
  output logic              oled_res_n
);
  state_t state;
  logic [9:0] entry;
  logic [1:0] op;
  logic [7:0] pay;
  logic adv, timer_load, expired;
  assign op = entry[9:8];
  assign pay = entry[7:0];
  assign timer_load = state == EXEC && op == OP_DELAY && pay != 8'd0;
  // every path that moves past the current entry funnels through adv
  assign adv = (state == EXEC && (op == OP_CTRL ? pay != CTRL_END : op == OP_DELAY && pay == 8'd0))
            || (state == SEND && tx_valid && tx_ready)
            || (state == DELAY && expired);
  ssd1306_ms_timer #(.CYCLES_PER_MS(CLK_FREQ_HZ / 1000)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(timer_load),
    .ms_count(pay),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      entry <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rom_addr <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      tx_dc <= 1'b0;
      oled_res_n <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERR:
          if (start) begin
            rom_addr <= '0;
            done <= 1'b0;
            err <= 1'b0;
            busy <= 1'b1;
            state <= FETCH;
          end
        FETCH: begin
          entry <= rom_dout[9:0];
          state <= EXEC;
        end
        EXEC:
          if (is_tx(op)) begin
            tx_valid <= 1'b1;
            tx_data <= pay;
            tx_dc <= op == OP_DATA;
            state <= SEND;
          end else if (timer_load) begin
            state <= DELAY;
          end else if (op == OP_CTRL) begin
            if (pay == CTRL_END) begin
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end
            if (pay == CTRL_RES_LO) oled_res_n <= 1'b0;
            if (pay == CTRL_RES_HI) oled_res_n <= 1'b1;
          end
        SEND: if (tx_ready) tx_valid <= 1'b0;
        default: ;
      endcase
      if (adv) begin
        if (&rom_addr) begin
          err <= 1'b1;
          busy <= 1'b0;
          state <= ERR;
        end else begin
          rom_addr <= rom_addr + ADDR_W'(1);
          state <= FETCH;
        end
      end
    end
endmodule

// File: tb/tb_ssd1306_init_sequencer.sv
// tb_ssd1306_init_sequencer: randomized scripts checked against an entry-cost model of the sequencer
module tb_ssd1306_init_sequencer;
  localparam int CPM = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tx_ready = 1'b0;
  logic busy, done, err, tx_valid, tx_dc, oled_res_n;
  logic [3:0] rom_addr;
  logic [9:0] rom_dout;
  logic [7:0] tx_data;
  logic [9:0] rom [16];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int checks = 0, passed = 0, stall = 0;
  logic model_res = 1'b1;
  assign rom_dout = rom[rom_addr];
  always #5 clk = ~clk;
  ssd1306_init_sequencer #(.ADDR_W(4), .DATA_W(10), .CLK_FREQ_HZ(4000)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_dc(tx_dc), .tx_ready(tx_ready), .oled_res_n(oled_res_n)
  );

  task automatic load_rom(input logic [9:0] s[$]);
    for (int i = 0; i < 16; i++) rom[i] = i < s.size() ? s[i] : 10'($urandom);
  endtask

  // each entry costs FETCH+EXEC plus its own work; panel-reset changes take effect after the entry
  task automatic model_run(output int t, output bit m_done, output bit m_err, output int m_addr, output int low);
    logic [1:0] op;
    logic [7:0] p;
    int c;
    exp_q.delete();
    t = 1; low = 0; m_done = 0; m_err = 0; m_addr = 0;
    for (int a = 0; a < 16; a++) begin
      op = rom[a][9:8];
      p = rom[a][7:0];
      c = op < 2'd2 ? 3 + stall : op == 2'd2 ? 2 + CPM * int'(p) : 2;
      if (!model_res) low += c;
      t += c;
      m_addr = a;
      if (op < 2'd2) exp_q.push_back({op[0], p});
      if (op == 2'd3 && p == 8'd0) begin
        m_done = 1;
        break;
      end
      if (op == 2'd3 && p == 8'd1) model_res = 1'b0;
      if (op == 2'd3 && p == 8'd2) model_res = 1'b1;
      if (a == 15) m_err = 1;
    end
  endtask

  task automatic run_check(input string name, input int start_at);
    int t, low, ma, cyc, age, lowc;
    bit md, me;
    logic [7:0] hd;
    logic hdc;
    model_run(t, md, me, ma, low);
    got_q.delete();
    @(negedge clk); start = 1'b1; tx_ready = 1'b0;
    @(negedge clk); start = 1'b0; cyc = 1;
    checks++;
    if ({busy, done, err} !== 3'b100) $display("FAIL %s start busy/done/err got %b want 100", name, {busy, done, err});
    else passed++;
    age = 0; lowc = 0;
    while (!(done || err) && cyc < 3000) begin
      if (!oled_res_n) lowc++;
      if (tx_valid) begin
        if (age == 0) begin
          hd = tx_data; hdc = tx_dc;
        end else begin
          checks++;
          if (tx_data !== hd || tx_dc !== hdc) $display("FAIL %s stall stable got %h/%b want %h/%b", name, tx_data, tx_dc, hd, hdc);
          else passed++;
        end
        tx_ready = age >= stall;
        if (tx_ready) begin
          got_q.push_back({tx_dc, tx_data});
          age = 0;
        end else age++;
      end else tx_ready = 1'($urandom_range(0, 1));
      start = cyc == start_at;
      @(negedge clk); cyc++;
    end
    start = 1'b0; tx_ready = 1'b0;
    checks++;
    if (cyc !== t) $display("FAIL %s cycles got %0d want %0d", name, cyc, t); else passed++;
    checks++;
    if ({busy, done, err} !== {1'b0, md, me}) $display("FAIL %s end busy/done/err got %b want %b", name, {busy, done, err}, {1'b0, md, me});
    else passed++;
    checks++;
    if (rom_addr !== 4'(ma)) $display("FAIL %s rom_addr got %0d want %0d", name, rom_addr, ma); else passed++;
    checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL %s byte count got %0d want %0d", name, got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL %s byte %0d got %h want %h", name, i, got_q[i], exp_q[i]); else passed++;
    end
    checks++;
    if (lowc !== low) $display("FAIL %s res_n low cycles got %0d want %0d", name, lowc, low); else passed++;
    checks++;
    if (oled_res_n !== model_res) $display("FAIL %s res_n end got %b want %b", name, oled_res_n, model_res); else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, rom_addr, tx_valid, tx_data, tx_dc, oled_res_n} !== 17'b0_0_0_0000_0_00000000_0_1)
      $display("FAIL reset outputs got %b", {busy, done, err, rom_addr, tx_valid, tx_data, tx_dc, oled_res_n});
    else passed++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, rom_addr} !== 5'd0) $display("FAIL idle hold busy/addr got %b want 00000", {busy, rom_addr}); else passed++;
  endtask

  task automatic test_basic;
    load_rom('{10'h0AE, 10'h155, 10'h300});
    stall = 0;
    run_check("basic", -1);
  endtask

  task automatic test_stall;
    load_rom('{10'h0AE, 10'h155, 10'h300});
    stall = 5;
    run_check("stall", -1);
  endtask

  task automatic test_res_delay;
    stall = 0;
    load_rom('{10'h301, 10'h203, 10'h302, 10'h300});
    run_check("res_delay3", -1);
    load_rom('{10'h301, 10'h200, 10'h302, 10'h300});
    run_check("res_delay0", -1);
  endtask

  task automatic test_no_end;
    logic [9:0] s[$];
    for (int i = 0; i < 16; i++) s.push_back({2'b00, 8'($urandom)});
    load_rom(s);
    stall = 0;
    run_check("no_end", -1);
  endtask

  task automatic test_start_busy;
    load_rom('{10'h0AE, 10'h155, 10'h300});
    stall = 0;
    run_check("start_busy", 4);
    run_check("rerun", -1);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      logic [9:0] s[$];
      logic [1:0] op;
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        op = 2'($urandom_range(0, 3));
        s.push_back(op < 2'd2 ? {op, 8'($urandom)} : op == 2'd2 ? {op, 8'($urandom_range(0, 3))} :
                    {op, $urandom_range(0, 2) == 0 ? 8'($urandom_range(3, 255)) : 8'($urandom_range(1, 2))});
      end
      s.push_back(10'h300);
      load_rom(s);
      stall = $urandom_range(0, 3);
      run_check($sformatf("rand%0d", r), -1);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    load_rom('{10'h0AE, 10'h155, 10'h300});
    stall = 0;
    @(negedge clk); start = 1'b1; tx_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!tx_valid && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (tx_valid !== 1'b1) $display("FAIL mid_send reach tx_valid got %b want 1", tx_valid); else passed++;
    rst = 1'b1; #1;
    checks++;
    if ({busy, done, err, rom_addr, tx_valid, tx_data, tx_dc, oled_res_n} !== 17'b0_0_0_0000_0_00000000_0_1)
      $display("FAIL mid_send reset got %b", {busy, done, err, rom_addr, tx_valid, tx_data, tx_dc, oled_res_n});
    else passed++;
    @(negedge clk); rst = 1'b0;
    load_rom('{10'h301, 10'h203, 10'h300});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, oled_res_n} !== 2'b10) $display("FAIL mid_delay pre busy/res_n got %b want 10", {busy, oled_res_n}); else passed++;
    rst = 1'b1; #1;
    checks++;
    if ({busy, done, err, rom_addr, tx_valid, tx_data, tx_dc, oled_res_n} !== 17'b0_0_0_0000_0_00000000_0_1)
      $display("FAIL mid_delay reset got %b", {busy, done, err, rom_addr, tx_valid, tx_data, tx_dc, oled_res_n});
    else passed++;
    @(negedge clk); rst = 1'b0;
    model_res = 1'b1;
    load_rom('{10'h0AE, 10'h155, 10'h300});
    run_check("after_reset", -1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_res_delay;
    test_no_end;
    test_start_busy;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
